// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: bundles the requester-side word handshake and the
// byte-wide transmitter handshake shared by the UART TX scheduler.
// The master modport is the environment side (producers plus transmitter).
// The slave modport is the scheduler side.
interface uart_tx_sched_if #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [7:0]         tx_sdata;
  logic               tx_start;
  logic               tx_busy;
  logic [1:0]         grant_id;
  logic               active;

  modport master (
    output req_valid,
    output req_data,
    output tx_busy,
    input  req_ready,
    input  tx_sdata,
    input  tx_start,
    input  grant_id,
    input  active
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  tx_busy,
    output req_ready,
    output tx_sdata,
    output tx_start,
    output grant_id,
    output active
  );

endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one byte-wide UART transmitter
// between NREQ word producers. Each grant sends one word, LSB byte first, as
// WORD_BYTES back-to-back bytes with no interleaving from other requesters.
// Optional feature macro UART_TX_SCHED_HDR_EN: when defined, every grant is
// prefixed by a header byte 8'hA0 | grant_id sent with the same handshake.
module uart_tx_sched #(
  parameter int NREQ       = 2,
  parameter int WORD_BYTES = 4
) (
  input logic            clk,
  input logic            rst,
  uart_tx_sched_if.slave io_bus
);

`ifdef UART_TX_SCHED_HDR_EN
  localparam int NBYTES = WORD_BYTES + 1;
  localparam int SHW    = 40;
`else
  localparam int NBYTES = WORD_BYTES;
  localparam int SHW    = 32;
`endif

  localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);
  localparam logic [1:0] PTR_INIT  = 2'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_grant;
  logic [2:0]       r_byteCnt;
  logic [SHW-1:0]   r_shift;
  logic [7:0]       r_sdata;
  logic             r_start;
  logic [NREQ-1:0]  r_ready;
  logic             r_active;

  logic             w_found;
  logic [1:0]       w_winner;
  logic [2:0]       w_idx;
  logic [31:0]      w_word;
  logic [NREQ-1:0]  w_onehot;
  logic [SHW-1:0]   w_initShift;
  logic [SHW-1:0]   w_shifted;

  // Round-robin search: scan from the requester after the last grant,
  // wrapping at NREQ; the closest valid requester overrides farther ones.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = {1'b0, r_ptr} + 3'(k);
      if (w_idx >= 3'(NREQ)) begin
        w_idx = w_idx - 3'(NREQ);
      end
      for (int j = 0; j < NREQ; j++) begin
        if ((w_idx == 3'(j)) && io_bus.req_valid[j]) begin
          w_found  = 1'b1;
          w_winner = 2'(j);
        end
      end
    end
  end

  // Select the winner's word and build its one-hot accept vector.
  always_comb begin
    w_word   = '0;
    w_onehot = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_winner == 2'(j)) begin
        w_word      = io_bus.req_data[32*j +: 32];
        w_onehot[j] = 1'b1;
      end
    end
  end

  // Byte sequence for a fresh grant, header in the low byte when enabled.
`ifdef UART_TX_SCHED_HDR_EN
  always_comb begin
    w_initShift = {w_word, (8'hA0 | {6'b0, w_winner})};
  end
`else
  always_comb begin
    w_initShift = w_word;
  end
`endif

  // Remaining bytes after the one currently on tx_sdata.
  always_comb begin
    w_shifted = r_shift >> 8;
  end

  // Main sequencer: grant, then one start/busy-rise/busy-fall per byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= PTR_INIT;
      r_grant   <= '0;
      r_byteCnt <= '0;
      r_shift   <= '0;
      r_sdata   <= '0;
      r_start   <= 1'b0;
      r_ready   <= '0;
      r_active  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!io_bus.tx_busy && w_found) begin
            r_shift   <= w_initShift;
            r_grant   <= w_winner;
            r_active  <= 1'b1;
            r_ready   <= w_onehot;
            r_sdata   <= w_initShift[7:0];
            r_start   <= 1'b1;
            r_byteCnt <= '0;
            r_state   <= START;
          end
        end
        START: begin
          r_start <= 1'b0;
          r_ready <= '0;
          r_state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (io_bus.tx_busy) begin
            r_state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!io_bus.tx_busy) begin
            if (r_byteCnt == LAST_BYTE) begin
              r_active <= 1'b0;
              r_ptr    <= r_grant;
              r_state  <= IDLE;
            end else begin
              r_shift   <= w_shifted;
              r_byteCnt <= r_byteCnt + 3'd1;
              r_sdata   <= w_shifted[7:0];
              r_start   <= 1'b1;
              r_state   <= START;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_bus.req_ready = r_ready;
  assign io_bus.tx_sdata  = r_sdata;
  assign io_bus.tx_start  = r_start;
  assign io_bus.grant_id  = r_grant;
  assign io_bus.active    = r_active;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized and directed bench for uart_tx_sched.
// A byte-queue model predicts every registered output each cycle; a simple
// transmitter model raises tx_busy the cycle after an accepted tx_start.
module tb_uart_tx_sched;

  localparam int NREQ = 2;
  localparam int WB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_sched_if #(.NREQ(NREQ)) bus ();

  uart_tx_sched #(.NREQ(NREQ), .WORD_BYTES(WB)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int busyLen      = 3;
  bit forceBusy    = 1'b0;
  int senderCnt    = 0;
  bit pendingStart = 1'b0;
  bit refill       = 1'b0;
  bit randMode     = 1'b0;
  bit checkEn      = 1'b0;

  logic [7:0] byteLog[$];
  int         grantLog[$];
  int         startCount     = 0;
  int         readyCount     = 0;
  int         readyWithStart = 0;

  // Behavioural model state
  bit              mActive = 1'b0;
  int              mGrant  = 0;
  int              mPtr    = NREQ - 1;
  int              mPhase  = 0;
  logic [7:0]      mQueue[$];
  logic            expStart = 1'b0;
  logic [NREQ-1:0] expReady = '0;
  logic [7:0]      expSdata = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] w);
    bus.req_data[32*idx +: 32] = w;
    bus.req_valid[idx]         = 1'b1;
  endtask

  task automatic setForceBusy(input bit v);
    forceBusy  = v;
    bus.tx_busy = (senderCnt > 0) || v;
  endtask

  // One clock of the model: grant by round-robin arithmetic, then emit the
  // queued bytes one per start / busy-rise / busy-fall handshake.
  task automatic modelStep();
    logic [NREQ-1:0] v;
    logic            b;
    logic [31:0]     word;
    int              w;
    int              c;
    v = bus.req_valid;
    b = bus.tx_busy;
    expStart = 1'b0;
    expReady = '0;
    if (!mActive) begin
      if (!b && (v != 0)) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          c = (mPtr + k) % NREQ;
          if (w < 0 && v[c]) w = c;
        end
        word = 32'(bus.req_data >> (32 * w));
        mQueue.delete();
`ifdef UART_TX_SCHED_HDR_EN
        mQueue.push_back(8'hA0 | 8'(w));
`endif
        for (int bi = 0; bi < WB; bi++) mQueue.push_back(word[8*bi +: 8]);
        expSdata = mQueue.pop_front();
        expStart = 1'b1;
        expReady = NREQ'(1) << w;
        mGrant   = w;
        mActive  = 1'b1;
        mPhase   = 0;
      end
    end else if (mPhase == 0) begin
      mPhase = 1;
    end else if (mPhase == 1) begin
      if (b) mPhase = 2;
    end else if (!b) begin
      if (mQueue.size() == 0) begin
        mActive = 1'b0;
        mPtr    = mGrant;
      end else begin
        expSdata = mQueue.pop_front();
        expStart = 1'b1;
        mPhase   = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive  = 1'b0;
      mGrant   = 0;
      mPtr     = NREQ - 1;
      mPhase   = 0;
      mQueue.delete();
      expStart = 1'b0;
      expReady = '0;
      expSdata = '0;
    end else begin
      modelStep();
    end
  end

  // Transmitter model: busy rises the cycle after tx_start is accepted.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        senderCnt    = 0;
        pendingStart = 1'b0;
      end else begin
        if (senderCnt > 0) senderCnt--;
        if (pendingStart) begin
          senderCnt    = randMode ? int'($urandom_range(1, 6)) : busyLen;
          pendingStart = 1'b0;
        end
        if (bus.tx_start) pendingStart = 1'b1;
        if (randMode && $urandom_range(0, 39) == 0) forceBusy = ~forceBusy;
      end
      bus.tx_busy = (senderCnt > 0) || forceBusy;
    end
  end

  // Requester agents: drop or refill on accept, random traffic when enabled.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_ready[i]) begin
          if (refill) bus.req_data[32*i +: 32] = $urandom;
          else        bus.req_valid[i] = 1'b0;
        end else if (randMode && !rst) begin
          if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
            bus.req_data[32*i +: 32] = $urandom;
            bus.req_valid[i]         = 1'b1;
          end else if (bus.req_valid[i] && $urandom_range(0, 59) == 0) begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  // Compare process plus byte/grant logging, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("tx_start", 32'(bus.tx_start), 32'(expStart));
        checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
        checkOutput("tx_sdata", 32'(bus.tx_sdata), 32'(expSdata));
        checkOutput("grant_id", 32'(bus.grant_id), 32'(mGrant));
        checkOutput("active", 32'(bus.active), 32'(mActive));
      end
      if (!rst) begin
        if (bus.tx_start) begin
          byteLog.push_back(bus.tx_sdata);
          startCount++;
        end
        if (bus.req_ready != 0) begin
          readyCount++;
          if (bus.tx_start) readyWithStart++;
          for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grantLog.push_back(i);
        end
      end
    end
  end

  task automatic waitForIdle(input int limit, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.active || bus.tx_busy || bus.req_valid != 0) && n < limit);
    checkOutput(name, 32'(bus.active || bus.tx_busy || bus.req_valid != 0), 32'd0);
  endtask

  task automatic waitForStarts(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (startCount < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(startCount >= target), 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst           = 1'b1;
    bus.req_valid = '0;
    refill        = 1'b0;
    setForceBusy(1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    logic [7:0] exp2[$];
    int         base;
    int         n;
    int         g;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("rst_tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_active", 32'(bus.active), 32'd0);
    checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("rst_tx_sdata", 32'(bus.tx_sdata), 32'd0);
    #1;
    rst = 1'b0;

    // Idle for 100 cycles with no requests
    repeat (100) @(negedge clk);
    checkOutput("idle_starts", 32'(startCount), 32'd0);
    checkOutput("idle_readies", 32'(readyCount), 32'd0);
    checkOutput("idle_grant_id", 32'(bus.grant_id), 32'd0);

    // Single word from requester 0 with a 20-cycle busy per byte
    busyLen = 20;
    byteLog.delete();
    grantLog.delete();
    startCount = 0; readyCount = 0; readyWithStart = 0;
    @(negedge clk); #1;
    applyStimulus(0, 32'h44332211);
    waitForIdle(500, "word0_timeout");
`ifdef UART_TX_SCHED_HDR_EN
    exp2 = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44};
`else
    exp2 = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    checkOutput("word0_nbytes", 32'(byteLog.size()), 32'(exp2.size()));
    for (int i = 0; i < exp2.size(); i++) begin
      checkOutput($sformatf("word0_byte%0d", i),
                  32'(i < byteLog.size() ? byteLog[i] : 8'hXX), 32'(exp2[i]));
    end
    checkOutput("word0_readies", 32'(readyCount), 32'd1);
    checkOutput("word0_ready_with_start", 32'(readyWithStart), 32'd1);

    // Two continuously valid requesters alternate
    doReset();
    busyLen = 3;
    grantLog.delete();
    refill = 1'b1;
    @(negedge clk); #1;
    applyStimulus(0, 32'hA1A2A3A4);
    applyStimulus(1, 32'hB1B2B3B4);
    n = 0;
    while (grantLog.size() < 4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    refill = 1'b0;
    checkOutput("rr_grants_seen", 32'(grantLog.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_grant%0d", i),
                  32'(i < grantLog.size() ? grantLog[i] : -1), 32'(i % 2));
    end
    waitForIdle(600, "rr_drain_timeout");

    // Busy held high externally blocks the grant until it falls
    @(negedge clk); #1;
    setForceBusy(1'b1);
    repeat (2) @(negedge clk);
    #1;
    applyStimulus(1, 32'h0BADF00D);
    base = startCount;
    n    = readyCount;
    repeat (30) @(negedge clk);
    checkOutput("hold_starts", 32'(startCount - base), 32'd0);
    checkOutput("hold_readies", 32'(readyCount - n), 32'd0);
    #1;
    setForceBusy(1'b0);
    @(posedge clk);
    #1;
    checkOutput("hold_release_ready", 32'(bus.req_ready), 32'b10);
    checkOutput("hold_release_start", 32'(bus.tx_start), 32'd1);
    waitForIdle(300, "hold_drain_timeout");

    // Asynchronous reset in the middle of a word
    doReset();
    busyLen = 4;
    @(negedge clk); #1;
    base = startCount;
    applyStimulus(0, 32'h01020304);
    applyStimulus(1, 32'h05060708);
    waitForStarts(base + 2, 200, "midrst_starts_timeout");
    n = 0;
    while (!bus.tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("midrst_active", 32'(bus.active), 32'd0);
    checkOutput("midrst_grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("midrst_tx_sdata", 32'(bus.tx_sdata), 32'd0);
    applyStimulus(0, 32'h11111111);
    applyStimulus(1, 32'h22222222);
    repeat (2) @(negedge clk);
    #1;
    grantLog.delete();
    rst = 1'b0;
    waitForStarts(startCount + 1, 50, "midrst_regrant_timeout");
    g = grantLog.size() > 0 ? grantLog[0] : -1;
    checkOutput("midrst_first_winner", 32'(g), 32'd0);
    waitForIdle(400, "midrst_drain_timeout");

    // Randomized traffic against the model
    randMode = 1'b1;
    repeat (3000) @(negedge clk);
    randMode = 1'b0;
    #1;
    setForceBusy(1'b0);
    waitForIdle(2000, "random_drain_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one byte-wide UART transmitter (tx_start/sdata/tx_busy interface) between NREQ word requesters. Each grant sends one 32-bit word as WORD_BYTES bytes, LSB first, back-to-back with no interleaving. It sits between core-side producers (e.g. print/debug and result-dump paths) and the single UART TX instance.

Parameters:
NREQ, 2, number of requesters; legal values 2..4.
WORD_BYTES, 4, bytes sent per grant, from req word LSB upward; legal values 1..4.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  NREQ  per-requester word pending; held until matching req_ready pulse.
req_data  input  NREQ*32  requester i word at bits [32*i+31:32*i]; held with valid.
req_ready  output  NREQ  one-cycle registered accept pulse, one-hot.
tx_sdata  output  8  byte to transmitter, stable from tx_start until next byte.
tx_start  output  1  one-cycle registered start pulse to transmitter.
tx_busy  input  1  transmitter busy; rises cycle after accepted tx_start, falls after stop bit.
grant_id  output  2  id of requester currently being served; last served when idle.
active  output  1  high from grant until last byte's tx_busy falls.

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=0; tx_start=0; tx_sdata=0; active=0; grant_id=0; last-grant pointer=NREQ-1, so requester 0 wins first; byte counter=0.
- States: IDLE, START, WAIT_HI, WAIT_LO.
- IDLE: grant only if tx_busy==0 and any req_valid. Winner is the first valid requester searching from pointer+1 upward, wrapping at NREQ.
- IDLE grant edge: latch winner's word into shift reg; grant_id=winner; active=1; req_ready[winner]=1 for exactly next cycle; tx_sdata=word[7:0]; tx_start=1; counter=0; go START.
- START (one cycle): tx_start=0, req_ready=0; go WAIT_HI.
- WAIT_HI: wait for tx_busy==1, then go WAIT_LO. No timeout.
- WAIT_LO: wait for tx_busy==0. Then:
  - if counter==WORD_BYTES-1: active=0; pointer=grant_id; go IDLE.
  - else: shift word right 8, counter+1, tx_sdata=next byte, tx_start=1, go START.
- Latency: valid sampled at cycle T in IDLE -> req_ready and tx_start high in T+1. After tx_busy falls (sampled low at U), next tx_start is high at U+1.
- Requester must keep valid/data until req_ready. Valid seen again in IDLE after service is treated as a new word.
- Fairness: a requester continuously asserting valid cannot be granted twice in a row while another requester is valid.
- Valid dropped before grant: no grant, no error. Valid changes during service are ignored; the word is already latched.
- tx_busy high in IDLE (transmitter driven elsewhere): hold off granting until it is low.
- Unused req_data bits above 8*WORD_BYTES are ignored.

Optional Feature:
UART_TX_SCHED_HDR_EN
- Defined: every grant first sends header byte 8'hA0|grant_id, then the WORD_BYTES data bytes. The header uses the same START/WAIT_HI/WAIT_LO handshake. req_ready timing is unchanged: it pulses with the header's tx_start. The counter covers WORD_BYTES+1 bytes.
- Undefined: no header; behaviour as above. Header logic must be fully compiled out.

Test Plan:
- Reset, req_valid=0, tx_busy model idle -> all outputs 0, grant_id=0, no tx_start for 100 cycles.
- req0 word 32'h44332211, sender model asserting busy 1 cycle after start for 20 cycles -> bytes 11,22,33,44 in order, 4 tx_start pulses, one req_ready[0] pulse in the first tx_start cycle, active drops 1 cycle after final busy fall.
- req0 and req1 both valid continuously with distinct words -> grant order 0,1,0,1; no word split or interleaved; each req_ready one cycle wide.
- tx_busy forced high while req1 becomes valid -> no req_ready, no tx_start until busy low; grant follows 1 cycle later.
- rst asserted mid-word after byte 2 -> outputs go to reset values immediately (async); after release, requester 0 wins when both are valid.
- With UART_TX_SCHED_HDR_EN, NREQ=3, req2 word 32'hDEADBEEF -> bytes A2,EF,BE,AD,DE.
